inst_fetch_if: RTL

- Responder side of the fetch interface driven by the PC register: consumes `pc`/`ce` and returns the instruction word for that PC.
- Converts each fetch into one transaction on an SRAM-like instruction bus (req/addr_ok/data_ok handshake).
- Raises `stallreq_o` to the pipeline controller until the word is available.
- Handles pipeline flush while a bus transaction is in flight.

---
 rtl/inst_fetch_if.sv | 133 +++++++++++++
 1 files changed

// File: rtl/inst_fetch_if.sv
// Instruction fetch interface: turns each PC fetch into a single transaction on
// an SRAM-like bus (req/addr_ok/data_ok), holds the returned word for the IF/ID
// stage and stalls the pipeline until that word is available. A flush that lands
// while a transaction is in flight has its late data discarded.
//
// Bus handshake: inst_req/inst_addr are raised from a register and held stable
// until the cycle the bus samples inst_addr_ok=1 (request accepted). The read
// data is valid only in a cycle where inst_data_ok=1, which may be the same cycle
// as inst_addr_ok. Only one transaction is outstanding at any time.
module inst_fetch_if #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ce,
    input  logic [5:0]        stall,
    input  logic              flush,
    output logic [DATA_W-1:0] inst_o,
    output logic              stallreq_o,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    input  logic              inst_data_ok,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        DONE    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] inst_buf;

    // Only stall[0] (PC hold) matters here; the upper stages are not our concern.
    logic stall_unused;
    assign stall_unused = ^stall[5:1];

    assign inst_addr = addr_q;
    assign dbg_state = state;

    // Stall request: the pipeline waits while a fetch is pending, but never
    // while the chip is disabled or held in reset.
    always_comb begin
        stallreq_o = 1'b0;
        if (!rst && ce) begin
            unique case (state)
                IDLE:              stallreq_o = !flush;
                REQ, WAIT, DISCARD: stallreq_o = 1'b1;
                default:           stallreq_o = 1'b0;
            endcase
        end
    end

    // Fetch FSM with registered bus request and instruction output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            inst_buf <= NOP_INST;
            inst_req <= 1'b0;
            inst_o   <= NOP_INST;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ce && !flush) begin
                        addr_q   <= pc;
                        inst_req <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (inst_addr_ok) begin
                        inst_req <= 1'b0;
                        if (flush) begin
                            // Accepted but no longer wanted: swallow the reply.
                            state <= inst_data_ok ? IDLE : DISCARD;
                        end else if (inst_data_ok) begin
                            inst_buf <= inst_rdata;
                            inst_o   <= inst_rdata;
                            state    <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (flush) begin
                        // Never accepted, so the request can simply be withdrawn.
                        inst_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            inst_buf <= inst_rdata;
                            inst_o   <= inst_rdata;
                            state    <= DONE;
                        end
                    end else if (flush) begin
                        state <= DISCARD;
                    end
                end
                DONE: begin
                    // Hold the word until the PC moves on or the pipe is flushed.
                    if (flush || !stall[0]) begin
                        inst_o <= NOP_INST;
                        state  <= IDLE;
                    end
                end
                DISCARD: begin
                    if (inst_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    inst_req <= 1'b0;
                    inst_o   <= NOP_INST;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
